regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Write-side initiator for the 16x32 register file: buffers writeback requests from execute/memory
//  and drains them one per cycle onto the regfile write port (we3/a3/wd3).
//  Writes to address 15 (PC) bypass the regfile and go out on a PC-write strobe.
//  Forwards pending data to both read ports (a1/a2) so reads never see stale values.
// PARAMETERS
//  DEPTH   4   queue entries, power of two, >=2
//  DATA_W  32  data width
//  ADDR_W  4   register address width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  in_valid    in   1       writeback request valid
//  in_ready    out  1       queue can accept; transfer when in_valid&in_ready
//  in_addr     in   ADDR_W  destination register
//  in_data     in   DATA_W  writeback value
//  hold        in   1       1 = do not drain this cycle
//  we3         out  1       regfile write enable
//  a3          out  ADDR_W  regfile write address
//  wd3         out  DATA_W  regfile write data
//  pc_we       out  1       PC write strobe (entry addr == 15)
//  pc_wd       out  DATA_W  PC write value
//  a1, a2      in   ADDR_W  regfile read addresses (snooped)
//  fwd1_hit    out  1       pending entry matches a1; use fwd1_data instead of rd1
//  fwd1_data   out  DATA_W
//  fwd2_hit    out  1       same for a2
//  fwd2_data   out  DATA_W
//  count       out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset: all entries discarded; count=0; we3=pc_we=fwd*_hit=0; a3/wd3/pc_wd=0.
//  - Circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH; count is the occupancy.
//  - drain = (count!=0) & ~hold. When drain, the head entry drives the outputs combinationally:
//    - head addr != 15: we3=1, a3=addr, wd3=data.
//    - head addr == 15: pc_we=1, pc_wd=data, we3=0.
//    - Pop at the clock edge. Outputs are 0 when not draining.
//  - in_ready = (count<DEPTH) | drain. Simultaneous push+pop when full is legal; count unchanged.
//  - Latency: push in cycle N -> earliest regfile write at edge ending cycle N+1 (empty queue, hold=0).
//  - Order preserved; two entries with the same addr are both written, oldest first.
//  - Forwarding:
//    - Scan all valid entries, head included; the youngest match wins.
//    - Addr 15 is never forwarded (regfile supplies PC+8 for r15).
//    - in_data of the current cycle is not forwarded.
//  - hold=1: no drain, pushes continue until full; forwarding stays active.
//  - Reset mid-drain: the entry at head is lost, no write occurs that cycle.
// STRUCTURE
//  - cpu_pkg:
//    - DATA_W, ADDR_W, PC_ADDR=4'hF.
//    - typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wb_entry_t.
//  - Sub-module wb_fwd_match:
//    - Combinational youngest-first priority search over DEPTH entries for one read address.
//    - Instantiated twice (a1, a2).
// TESTING (bench drives the real regfile from we3/a3/wd3)
//  1. Push (r1,0x11),(r2,0x22),(r3,0x33) back-to-back with hold=0 -> we3 high 3 cycles, a3=1,2,3;
//     afterwards rd1 reads r2=0x22.
//  2. hold=1, push (r4,0xA),(r4,0xB) then a1=4 -> fwd1_hit=1, fwd1_data=0xB.
//     Release hold -> regfile r4=0xB after 2 cycles, fwd1_hit=0.
//  3. hold=1, push DEPTH=4 entries -> in_ready=0, count=4.
//     hold=0 with a push same cycle -> accepted, count stays 4.
//  4. Push (r15,1515) -> pc_we=1, pc_wd=1515, we3=0.
//     a1=15 during pend -> fwd1_hit=0.
//  5. Queue 3 entries under hold, assert reset 1 cycle -> count=0, no regfile write, in_ready=1.
//  6. a1=a2=5 with r5 pending 0x55 -> both fwd hits, data 0x55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and the writeback queue entry type.
// Used by the regfile writeback queue and its forwarding matcher.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PC_ADDR = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of the pending writeback entries for one read address.
// Entry 0 is the oldest. The PC address never matches.
module wb_fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [ADDR_W-1:0]     raddr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [DEPTH-1:0] match_s;

  // Later (younger) matches override earlier ones as the loop walks forward.
  always_comb begin
    hit  = 1'b0;
    data = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid[i] && (entries[i].addr == raddr) && (raddr != PC_ADDR);
      hit        = hit | match_s[i];
      data       = match_s[i] ? entries[i].data : data;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the regfile write port; PC writes leave on pc_we,
// and pending data is forwarded to both read ports.
module regfile_wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       hold,
  output logic                       we3,
  output logic [ADDR_W-1:0]          a3,
  output logic [DATA_W-1:0]          wd3,
  output logic                       pc_we,
  output logic [DATA_W-1:0]          pc_wd,
  input  logic [ADDR_W-1:0]          a1,
  input  logic [ADDR_W-1:0]          a2,
  output logic                       fwd1_hit,
  output logic [DATA_W-1:0]          fwd1_data,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t              mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic                   drain_s;
  logic                   push_s;
  wb_entry_t              head_s;
  wb_entry_t [DEPTH-1:0]  aged_s;
  logic [DEPTH-1:0]       aged_vld_s;
  logic                   hit1_s;
  logic                   hit2_s;
  logic [DATA_W-1:0]      data1_s;
  logic [DATA_W-1:0]      data2_s;

  assign count = count_r;

  // Drain control and write-port drive; reset suppresses the head write.
  always_comb begin
    head_s   = mem_r[rd_ptr_r];
    drain_s  = (count_r != CNT_W'(0)) && !hold && !reset;
    in_ready = (count_r < CNT_W'(DEPTH)) || drain_s;
    push_s   = in_valid && in_ready;
    we3      = 1'b0;
    a3       = {ADDR_W{1'b0}};
    wd3      = {DATA_W{1'b0}};
    pc_we    = 1'b0;
    pc_wd    = {DATA_W{1'b0}};
    if (drain_s) begin
      if (head_s.addr == PC_ADDR) begin
        pc_we = 1'b1;
        pc_wd = head_s.data;
      end else begin
        we3 = 1'b1;
        a3  = head_s.addr;
        wd3 = head_s.data;
      end
    end else begin
      we3   = 1'b0;
      pc_we = 1'b0;
    end
  end

  // Present the ring in age order so the matcher can prefer the youngest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      aged_s[i]     = mem_r[rd_ptr_r + PTR_W'(i)];
      aged_vld_s[i] = (CNT_W'(i) < count_r);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (aged_s),
    .valid   (aged_vld_s),
    .raddr   (a1),
    .hit     (hit1_s),
    .data    (data1_s)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (aged_s),
    .valid   (aged_vld_s),
    .raddr   (a2),
    .hit     (hit2_s),
    .data    (data2_s)
  );

  assign fwd1_hit  = hit1_s && !reset;
  assign fwd1_data = data1_s;
  assign fwd2_hit  = hit2_s && !reset;
  assign fwd2_data = data2_s;

  // Ring storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= wb_entry_t'(0);
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{addr: in_addr, data: in_data};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a behavioural 16x32 regfile
// written from we3/a3/wd3.
module tb_regfile_wb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        we3;
  logic [3:0]  a3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [3:0]  a1;
  logic [3:0]  a2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;

  logic [31:0] rf [16];
  int n_total;
  int n_pass;

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .hold      (hold),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd),
    .a1        (a1),
    .a2        (a2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we3) rf[a3] <= wd3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [3:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_addr  = 4'h0;
    in_data  = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    reset = 1'b1; hold = 1'b0; a1 = 4'h0; a2 = 4'h0;
    idle();
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_a3_wd3", {28'h0, a3} | wd3, 32'd0);
    check("rst_fwd", {30'h0, fwd1_hit, fwd2_hit}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: three back-to-back pushes drain in order
    step();
    push(4'd1, 32'h11); @(negedge clk); check("t1_we3_c0", 32'(we3), 32'd0); step();
    push(4'd2, 32'h22); @(negedge clk);
    check("t1_a3_1", 32'(a3), 32'd1); check("t1_wd3_1", wd3, 32'h11); check("t1_we3_1", 32'(we3), 32'd1);
    step();
    push(4'd3, 32'h33); @(negedge clk); check("t1_a3_2", 32'(a3), 32'd2); step();
    idle(); @(negedge clk);
    check("t1_a3_3", 32'(a3), 32'd3); check("t1_wd3_3", wd3, 32'h33); step();
    @(negedge clk);
    check("t1_we3_done", 32'(we3), 32'd0); check("t1_count", 32'(count), 32'd0);
    check("t1_rf1", rf[1], 32'h11); check("t1_rf2", rf[2], 32'h22); check("t1_rf3", rf[3], 32'h33);

    // 2: same-address entries under hold, youngest forwarded, oldest written first
    step();
    hold = 1'b1;
    push(4'd4, 32'hA); step();
    push(4'd4, 32'hB); step();
    idle(); a1 = 4'd4; @(negedge clk);
    check("t2_hit", 32'(fwd1_hit), 32'd1); check("t2_data", fwd1_data, 32'hB);
    check("t2_count", 32'(count), 32'd2); check("t2_hold_we3", 32'(we3), 32'd0);
    step();
    hold = 1'b0; @(negedge clk);
    check("t2_wd3_old", wd3, 32'hA); check("t2_hit_d1", fwd1_data, 32'hB); step();
    @(negedge clk); check("t2_wd3_new", wd3, 32'hB); step();
    @(negedge clk);
    check("t2_hit_gone", 32'(fwd1_hit), 32'd0); check("t2_rf4", rf[4], 32'hB);

    // 3: full queue, then push+pop in the same cycle
    step();
    hold = 1'b1; a1 = 4'd0;
    for (int k = 0; k < 4; k++) begin
      push(4'(6 + k), 32'h60 + 32'(k)); step();
    end
    idle(); @(negedge clk);
    check("t3_full_ready", 32'(in_ready), 32'd0); check("t3_full_count", 32'(count), 32'd4);
    step();
    hold = 1'b0; push(4'd10, 32'h10A); @(negedge clk);
    check("t3_ready_drain", 32'(in_ready), 32'd1); check("t3_a3_6", 32'(a3), 32'd6); step();
    idle(); @(negedge clk);
    check("t3_count_kept", 32'(count), 32'd4); check("t3_a3_7", 32'(a3), 32'd7);
    for (int k = 8; k <= 10; k++) begin
      step(); @(negedge clk); check("t3_a3_seq", 32'(a3), 32'(k));
    end
    check("t3_wd3_last", wd3, 32'h10A);
    step(); @(negedge clk); check("t3_empty", 32'(count), 32'd0);

    // 4: PC write goes out on pc_we, never forwarded
    step();
    hold = 1'b1; push(4'd15, 32'd1515); step();
    idle(); a1 = 4'd15; @(negedge clk);
    check("t4_no_fwd", 32'(fwd1_hit), 32'd0); check("t4_pc_held", 32'(pc_we), 32'd0); step();
    hold = 1'b0; @(negedge clk);
    check("t4_pc_we", 32'(pc_we), 32'd1); check("t4_pc_wd", pc_wd, 32'd1515); check("t4_we3", 32'(we3), 32'd0);
    step(); @(negedge clk);
    check("t4_pc_we_off", 32'(pc_we), 32'd0); check("t4_rf15", rf[15], 32'd0);

    // 5: reset with pending entries discards them
    step();
    hold = 1'b1; a1 = 4'd0;
    push(4'd11, 32'hB1); step();
    push(4'd12, 32'hB2); step();
    push(4'd13, 32'hB3); step();
    idle(); reset = 1'b1; hold = 1'b0; @(negedge clk);
    check("t5_no_write_rst", 32'(we3), 32'd0); check("t5_no_fwd_rst", 32'(fwd1_hit), 32'd0); step();
    reset = 1'b0; @(negedge clk);
    check("t5_count", 32'(count), 32'd0); check("t5_ready", 32'(in_ready), 32'd1); check("t5_we3", 32'(we3), 32'd0);
    check("t5_rf11", rf[11], 32'd0);

    // 6: both read ports forward the same pending entry; in_data is not forwarded
    step();
    hold = 1'b1; a1 = 4'd5; a2 = 4'd5; push(4'd5, 32'h55); @(negedge clk);
    check("t6_no_fwd_in", 32'(fwd1_hit), 32'd0); step();
    idle(); @(negedge clk);
    check("t6_hit1", 32'(fwd1_hit), 32'd1); check("t6_data1", fwd1_data, 32'h55);
    check("t6_hit2", 32'(fwd2_hit), 32'd1); check("t6_data2", fwd2_data, 32'h55);
    hold = 1'b0; step(); @(negedge clk);
    check("t6_hit_clear", 32'(fwd2_hit), 32'd0); check("t6_rf5", rf[5], 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
